// File: rtl/spi_panel_pkg.sv
// Shared types and widths for the SPI panel controller and its key buffer.
// Configuration macro: SPI_PANEL_KEYFIFO_EN (see spi_key_fifo).
package spi_panel_pkg;

    localparam int KP_W               = 5;
    localparam int SEL_W              = 4;
    localparam int DATA_W             = 8;
    localparam int KEY_FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD      = 3'd2,
        WAIT_DATA = 3'd3,
        COMMIT    = 3'd4
    } panel_state_e;

    // Frame fields latched at pnl_received and used for the rest of the frame.
    typedef struct packed {
        logic [KP_W-1:0]  keypad;
        logic [SEL_W-1:0] in_sel;
        logic             key;
        logic             sel;
    } frame_fields_t;

endpackage

// File: rtl/spi_key_fifo.sv
// Keypad code buffer: DEPTH-entry FIFO when SPI_PANEL_KEYFIFO_EN is defined,
// otherwise a single overwrite-on-push holding register.
module spi_key_fifo
    import spi_panel_pkg::*;
#(
    parameter int DEPTH = KEY_FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [KP_W-1:0] push_code_i,
    input  logic            ack_i,
    input  logic            clr_ovf_i,
    output logic [KP_W-1:0] key_code_o,
    output logic            key_valid_o,
    output logic            key_ovf_o
);

    logic ovf_set;
    logic ovf_q;

`ifdef SPI_PANEL_KEYFIFO_EN
    localparam int PTR_W = $clog2(DEPTH);

    logic [KP_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             pop;
    logic             full;
    logic             push_ok;

    assign pop     = ack_i && (count_q != '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push_ok = push_i && (!full || pop);
    assign ovf_set = push_i && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty count already hides stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_code_i;
    end

    assign key_valid_o = (count_q != '0);
    assign key_code_o  = key_valid_o ? mem_q[rd_ptr_q] : '0;
`else
    logic [KP_W-1:0] code_q;
    logic            valid_q;
    logic            pop;
    logic [4:0]      unused_depth;

    assign unused_depth = 5'(DEPTH);
    assign pop          = ack_i && valid_q;
    assign ovf_set      = push_i && valid_q && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else if (push_i) begin
            code_q  <= push_code_i;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = valid_q ? code_q : '0;
`endif

    // A fresh overflow in the same cycle as a clear is kept: it is a newer event.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign key_ovf_o = ovf_q;

endmodule

// File: rtl/spi_panel_ctrl.sv
// Panel-side frame controller for a 24-bit SPI slave: readback, register write,
// keypad buffering and panel reset. Configuration macro: SPI_PANEL_KEYFIFO_EN.
module spi_panel_ctrl
    import spi_panel_pkg::*;
#(
    parameter int KEY_FIFO_DEPTH = KEY_FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              kbd_received,
    input  logic              pnl_received,
    input  logic              data_received,
    input  logic              SPI_End,
    input  logic [KP_W-1:0]   KeyPad,
    input  logic [SEL_W-1:0]  OutSel,
    input  logic [SEL_W-1:0]  InSel,
    input  logic              KEY,
    input  logic              RST,
    input  logic              SEL,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              data_ready,
    output logic [SEL_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              reg_wr,
    output logic [SEL_W-1:0]  reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [KP_W-1:0]   key_code,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              pnl_reset,
    output logic              key_ovf
);

    panel_state_e      state_q,      state_d;
    frame_fields_t     fields_q,     fields_d;
    logic [DATA_W-1:0] data_out_q,   data_out_d;
    logic              data_ready_q, data_ready_d;
    logic [SEL_W-1:0]  rd_addr_q,    rd_addr_d;
    logic              reg_wr_q,     reg_wr_d;
    logic [SEL_W-1:0]  reg_addr_q,   reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q,  reg_wdata_d;
    logic              pnl_reset_q,  pnl_reset_d;
    logic              key_push;
    logic              unused_kbd;

    // Every field arrives with pnl_received; the keypad strobe carries nothing extra.
    assign unused_kbd = kbd_received;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches.
        state_d      = state_q;
        fields_d     = fields_q;
        data_out_d   = data_out_q;
        data_ready_d = data_ready_q;
        rd_addr_d    = rd_addr_q;
        reg_wr_d     = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        pnl_reset_d  = 1'b0;

        if (SPI_End && (state_q != IDLE)) begin
            // End of frame wins over a same-cycle data_received.
            state_d      = IDLE;
            data_ready_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pnl_received) begin
                        fields_d.keypad = KeyPad;
                        fields_d.in_sel = InSel;
                        fields_d.key    = KEY;
                        fields_d.sel    = SEL;
                        rd_addr_d       = OutSel;
                        pnl_reset_d     = RST;
                        state_d         = FETCH;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    data_out_d   = rd_data;
                    data_ready_d = 1'b1;
                    state_d      = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (data_received) begin
                        reg_wr_d = fields_q.sel;
                        if (fields_q.sel) begin
                            reg_addr_d  = fields_q.in_sel;
                            reg_wdata_d = DataIn;
                        end
                        state_d = COMMIT;
                    end
                end
                COMMIT:  state_d = COMMIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together.
        if (reset) begin
            state_q      <= IDLE;
            fields_q     <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            rd_addr_q    <= '0;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            pnl_reset_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fields_q     <= fields_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            rd_addr_q    <= rd_addr_d;
            reg_wr_q     <= reg_wr_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            pnl_reset_q  <= pnl_reset_d;
        end
    end

    // Key push and panel reset share the cycle after pnl_received (FETCH).
    assign key_push = (state_q == FETCH) && fields_q.key;

    spi_key_fifo #(
        .DEPTH (KEY_FIFO_DEPTH)
    ) u_key_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (key_push),
        .push_code_i (fields_q.keypad),
        .ack_i       (key_ack),
        .clr_ovf_i   (pnl_reset_q),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_ovf_o   (key_ovf)
    );

    assign DataOut    = data_out_q;
    assign data_ready = data_ready_q;
    assign rd_addr    = rd_addr_q;
    assign reg_wr     = reg_wr_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign pnl_reset  = pnl_reset_q;

endmodule

// File: tb/tb_spi_panel_ctrl.sv
// Self-checking bench for spi_panel_ctrl: directed frames plus randomized frames
// against a frame-level reference model (key queue, overflow flag, write count).
module tb_spi_panel_ctrl;

    localparam int DEPTH = 4;
`ifdef SPI_PANEL_KEYFIFO_EN
    localparam int CAP       = DEPTH;
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam int CAP       = 1;
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kbd_received = 1'b0;
    logic       pnl_received = 1'b0;
    logic       data_received = 1'b0;
    logic       SPI_End = 1'b0;
    logic [4:0] KeyPad = '0;
    logic [3:0] OutSel = '0;
    logic [3:0] InSel = '0;
    logic       KEY = 1'b0;
    logic       RST = 1'b0;
    logic       SEL = 1'b0;
    logic [7:0] DataIn = '0;
    logic [7:0] DataOut;
    logic       data_ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       reg_wr;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic       pnl_reset;
    logic       key_ovf;

    spi_panel_ctrl #(.KEY_FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .kbd_received  (kbd_received),
        .pnl_received  (pnl_received),
        .data_received (data_received),
        .SPI_End       (SPI_End),
        .KeyPad        (KeyPad),
        .OutSel        (OutSel),
        .InSel         (InSel),
        .KEY           (KEY),
        .RST           (RST),
        .SEL           (SEL),
        .DataIn        (DataIn),
        .DataOut       (DataOut),
        .data_ready    (data_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .key_code      (key_code),
        .key_valid     (key_valid),
        .key_ack       (key_ack),
        .pnl_reset     (pnl_reset),
        .key_ovf       (key_ovf)
    );

    always #5 clk = ~clk;

    // Readback memory with one cycle of latency from rd_addr.
    logic [7:0] rd_mem [16];
    always @(posedge clk) rd_data <= rd_mem[rd_addr];

    int wr_seen  = 0;
    int rst_seen = 0;
    always @(negedge clk) begin
        if (reg_wr)    wr_seen++;
        if (pnl_reset) rst_seen++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: key buffer as a queue, overflow flag, pulse counts.
    int kq[$];
    bit m_ovf   = 1'b0;
    int exp_wr  = 0;
    int exp_rst = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_key(input bit key, input bit rst, input int code, input bit ack);
        bit popped;
        popped = ack && (kq.size() > 0);
        if (rst) m_ovf = 1'b0;
        if (key && (kq.size() == CAP) && !popped) begin
            m_ovf = 1'b1;
            if (!FIFO_MODE) kq[0] = code;
        end else begin
            if (popped) kq.delete(0);
            if (key) kq.push_back(code);
        end
    endfunction

    task automatic check_keys(input string tag);
        check({tag, "_valid"}, key_valid, kq.size() > 0);
        check({tag, "_code"}, key_code, (kq.size() > 0) ? kq[0] : 0);
        check({tag, "_ovf"}, key_ovf, m_ovf);
    endtask

    task automatic ack_one();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        model_key(1'b0, 1'b0, 0, 1'b1);
        check_keys("ack");
    endtask

    // mode 0: data then SPI_End; 1: SPI_End before data; 2: both in one cycle.
    task automatic frame(input logic [4:0] kp, input logic [3:0] osel, input logic [3:0] isel,
                         input bit key, input bit rst, input bit sel, input logic [7:0] din,
                         input int mode, input bit ack_push, input bit stray);
        logic [7:0] exp_do;
        int         gap;
        exp_do = rd_mem[osel];
        KeyPad = kp; OutSel = osel; InSel = isel; KEY = key; RST = rst; SEL = sel;
        pnl_received = 1'b1;
        tick();
        pnl_received = 1'b0;
        KeyPad = 5'($urandom); OutSel = 4'($urandom); InSel = 4'($urandom);
        KEY = 1'($urandom); RST = 1'($urandom); SEL = 1'($urandom);
        key_ack = ack_push;
        check("pnl_reset_slot", pnl_reset, rst);
        check("dr_fetch", data_ready, 0);
        tick();
        key_ack = 1'b0;
        model_key(key, rst, kp, ack_push);
        if (rst) exp_rst++;
        check("pnl_reset_end", pnl_reset, 0);
        check("dr_load", data_ready, 0);
        tick();
        check("dr_rise", data_ready, 1);
        check("data_out", DataOut, exp_do);
        check_keys("push");
        if (mode == 0) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                if (stray) begin
                    pnl_received = 1'b1; KEY = 1'b1; RST = 1'b1; KeyPad = 5'h1E;
                end
                tick();
                pnl_received = 1'b0;
                check("dr_hold", data_ready, 1);
            end
            data_received = 1'b1;
            DataIn = din;
            tick();
            data_received = 1'b0;
            DataIn = 8'($urandom);
            check("reg_wr", reg_wr, sel);
            if (sel) begin
                exp_wr++;
                check("reg_addr", reg_addr, isel);
                check("reg_wdata", reg_wdata, din);
            end
            data_received = 1'b1;
            tick();
            data_received = 1'b0;
            check("reg_wr_once", reg_wr, 0);
            check("dr_commit", data_ready, 1);
            SPI_End = 1'b1;
            tick();
            SPI_End = 1'b0;
            check("dr_clear", data_ready, 0);
        end else begin
            SPI_End = 1'b1;
            data_received = (mode == 2);
            DataIn = din;
            tick();
            SPI_End = 1'b0;
            check("dr_clear_early", data_ready, 0);
            check("no_wr_end", reg_wr, 0);
            data_received = 1'b1;
            tick();
            data_received = 1'b0;
            check("no_wr_idle", reg_wr, 0);
            tick();
            check("no_wr_late", reg_wr, 0);
        end
        check_keys("frame_end");
        check("wr_count", wr_seen, exp_wr);
        check("rst_count", rst_seen, exp_rst);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rd_mem[i] = 8'($urandom);
        rd_mem[5] = 8'hA7;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_dataout", DataOut, 0);
        check("rst_dr", data_ready, 0);
        check("rst_rdaddr", rd_addr, 0);
        check("rst_regwr", reg_wr, 0);
        check("rst_pnlrst", pnl_reset, 0);
        check_keys("rst");

        // Reference frame, then SEL=0, early end and same-cycle end.
        frame(5'h13, 4'd5, 4'd9, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 1'b0, 1'b0);
        check("ref_key_code", key_code, 5'h13);
        check("ref_key_valid", key_valid, 1);
        ack_one();
        frame(5'h02, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0, 8'h5A, 0, 1'b0, 1'b0);
        frame(5'h04, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 8'h66, 1, 1'b0, 1'b0);
        frame(5'h05, 4'd6, 4'd4, 1'b0, 1'b0, 1'b1, 8'h77, 2, 1'b0, 1'b0);

        // Overflow: one more key frame than the buffer holds, then drain.
        for (int i = 0; i <= CAP; i++)
            frame(5'(i + 1), 4'(i), 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        check("ovf_set", key_ovf, 1);
        check("ovf_head", key_code, FIFO_MODE ? 1 : CAP + 1);
        for (int i = 0; i < CAP; i++) begin
            check("drain_order", key_code, FIFO_MODE ? i + 1 : CAP + 1);
            ack_one();
        end
        frame(5'h00, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        check("ovf_cleared", key_ovf, 0);

        // Full buffer with push and ack in the same cycle.
        for (int i = 0; i < CAP; i++)
            frame(5'(5'h10 + i), 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0);
        frame(5'h1F, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b0);
        check("full_pp_ovf", key_ovf, 0);
        check("full_pp_head", key_code, FIFO_MODE ? 5'h11 : 5'h1F);
        for (int i = 0; i <= CAP; i++) ack_one();

        // Reset while waiting for data: the frame is abandoned.
        KeyPad = 5'h0A; OutSel = 4'd5; InSel = 4'd3; KEY = 1'b1; RST = 1'b0; SEL = 1'b1;
        pnl_received = 1'b1;
        tick();
        pnl_received = 1'b0;
        repeat (2) tick();
        check("pre_rst_dr", data_ready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        kq.delete();
        m_ovf = 1'b0;
        data_received = 1'b1;
        DataIn = 8'h55;
        tick();
        data_received = 1'b0;
        check("rst_mid_wr", reg_wr, 0);
        SPI_End = 1'b1;
        tick();
        SPI_End = 1'b0;
        check("rst_mid_wr2", reg_wr, 0);
        check("rst_mid_dataout", DataOut, 0);
        check("rst_mid_dr", data_ready, 0);
        check("rst_mid_rdaddr", rd_addr, 0);
        check("rst_mid_regaddr", reg_addr, 0);
        check("rst_mid_wdata", reg_wdata, 0);
        check("rst_mid_pnlrst", pnl_reset, 0);
        check_keys("rst_mid");
        check("rst_mid_wr_count", wr_seen, exp_wr);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) rd_mem[$urandom_range(0, 15)] = 8'($urandom);
            frame(5'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, 1'($urandom),
                  8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) < 3);
            if ($urandom_range(0, 9) < 3) ack_one();
        end

        check("final_wr_count", wr_seen, exp_wr);
        check("final_rst_count", rst_seen, exp_rst);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_panel_ctrl.md
SPI_PANEL_CTRL -- requirements
Module: spi_panel_ctrl

Interface
REQ-001 Parameter KEY_FIFO_DEPTH, default 4, keypad FIFO entries; power of two, 2..16.
REQ-002 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 kbd_received, pnl_received, data_received  in  1 each  one-cycle strobes from the 24-bit SPI slave.
REQ-005 SPI_End  in  1  one-cycle end-of-frame strobe.
REQ-006 KeyPad  in  5  keypad code; OutSel, InSel  in  4 each  readback and write selects; KEY, RST, SEL  in  1 each  panel flags.
REQ-007 DataIn  in  8  received data byte.
REQ-008 DataOut  out  8  readback byte to slave; data_ready  out  1  load request to slave.
REQ-009 rd_addr  out  4  readback address; rd_data  in  8  readback value, valid one cycle after rd_addr.
REQ-010 reg_wr  out  1  write strobe; reg_addr  out  4; reg_wdata  out  8.
REQ-011 key_code  out  5; key_valid  out  1; key_ack  in  1  keypad consumer handshake.
REQ-012 pnl_reset  out  1  one-cycle panel reset pulse; key_ovf  out  1  sticky overflow flag.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, LOAD, WAIT_DATA, COMMIT.
REQ-014 IDLE: on pnl_received, capture KeyPad, OutSel, InSel, KEY, RST, SEL; set rd_addr=OutSel; go to FETCH.
REQ-015 kbd_received SHALL be ignored; all fields are taken at pnl_received.
REQ-016 FETCH lasts one cycle; then go to LOAD.
REQ-017 LOAD: register rd_data into DataOut, set data_ready=1, go to WAIT_DATA; data_ready SHALL rise exactly 2 cycles after pnl_received.
REQ-018 data_ready SHALL stay high until SPI_End, then clear in the next cycle.
REQ-019 WAIT_DATA: on data_received, go to COMMIT; on SPI_End, go to IDLE with no write.
REQ-020 COMMIT: if captured SEL=1, pulse reg_wr for one cycle with reg_addr=InSel and reg_wdata=DataIn; go to WAIT_DATA-equivalent idle wait until SPI_End, then IDLE.
REQ-021 SPI_End in any non-IDLE state SHALL return the FSM to IDLE next cycle; SPI_End takes priority over data_received in the same cycle, so no write occurs.
REQ-022 pnl_received outside IDLE SHALL be ignored.
REQ-023 Captured KEY=1 SHALL push the captured KeyPad into the key FIFO in the cycle after pnl_received.
REQ-024 Captured RST=1 SHALL pulse pnl_reset for exactly one cycle, coincident with the key push slot.
REQ-025 key_valid=1 whenever the FIFO is non-empty; key_code shows the head entry; key_ack with key_valid pops one entry; key_ack without key_valid is ignored.
REQ-026 Push when full SHALL drop the new code and set key_ovf; push and pop in the same cycle when full SHALL succeed with no overflow.
REQ-027 key_ovf SHALL clear only on reset or pnl_reset.
REQ-028 FIFO pointers SHALL be log2(KEY_FIFO_DEPTH) bits wide and wrap modulo depth; count SHALL be one bit wider.

Reset
REQ-029 On reset: FSM=IDLE; DataOut=0, data_ready=0, rd_addr=0, reg_wr=0, reg_addr=0, reg_wdata=0, pnl_reset=0, key_ovf=0; FIFO empty, so key_valid=0 and key_code=0.
REQ-030 Reset mid-frame SHALL abort the frame with no reg_wr; the rest of that frame is ignored until the next pnl_received in IDLE.

Configuration
REQ-031 Macro SPI_PANEL_KEYFIFO_EN defined: key buffer SHALL be the KEY_FIFO_DEPTH-entry FIFO.
REQ-032 Not defined: key buffer SHALL be a single holding register; a push while valid overwrites it and sets key_ovf; a push with a simultaneous pop does not set key_ovf.

Structure
REQ-033 Shared package spi_panel_pkg SHALL hold the FSM state enum, the field widths (KP=5, SEL=4, DATA=8) and the default KEY_FIFO_DEPTH.
REQ-034 Key buffering SHALL be a sub-module spi_key_fifo; the FSM and the capture logic stay in spi_panel_ctrl.

Verification
REQ-035 Frame KeyPad=0x13, KEY=1, OutSel=5, InSel=9, SEL=1, rd_data[5]=0xA7, DataIn=0x3C -> data_ready rises 2 cycles after pnl_received; DataOut=0xA7; one reg_wr with addr 9 and data 0x3C; key_code=0x13 with key_valid=1.
REQ-036 SEL=0 frame -> no reg_wr; SPI_End before data_received -> no reg_wr, FSM back in IDLE, data_ready low the next cycle.
REQ-037 Five KEY frames without key_ack, depth 4 -> four entries held, key_ovf=1; four acks drain codes in order; a RST=1 frame clears key_ovf and gives a single pnl_reset pulse.
REQ-038 FIFO full with key_ack and push in the same cycle -> count stays 4, key_ovf stays 0, head advances.
REQ-039 reset asserted in WAIT_DATA, then data_received -> no reg_wr; all outputs at the REQ-029 values.
REQ-040 Macro undefined: two KEY frames without ack -> key_code holds the second code, key_ovf=1.
